prf_wb_arbiter: RTL and testbench
=================================

Name: prf_wb_arbiter

Overview:
Shares the physical register file's single writeback port between NUM_REQ functional-unit completion streams.
- Each requester gets a 1-entry holding buffer.
- Buffered results are granted round-robin onto a registered wb_* bus that drives the PRF write port.
- Results tagged with a stale epoch (wrong-path after mispredict recovery) are discarded here and counted, so they never consume PRF write bandwidth.

Parameters:
- NUM_REQ, 4, number of requesters (FU completion ports), >= 2.
- PHYS_REGS, 64, physical register count.
- DW, 32, data width.
- PHYS_W, $clog2(PHYS_REGS), physical register index width.
- EPOCH_W, 2, epoch tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  [NUM_REQ] x 1  requester i has a result.
- req_ready  out  [NUM_REQ] x 1  arbiter accepts from requester i this cycle.
- req_pd  in  [NUM_REQ] x PHYS_W  destination physical register.
- req_data  in  [NUM_REQ] x DW  result data.
- req_epoch  in  [NUM_REQ] x EPOCH_W  epoch tag of the producing instruction.
- flush_valid  in  1  mispredict recovery; a new epoch becomes current.
- flush_epoch  in  EPOCH_W  new current epoch.
- wb_valid  out  1  PRF write strobe.
- wb_pd  out  PHYS_W  PRF write index.
- wb_data  out  DW  PRF write data.
- wb_epoch  out  EPOCH_W  epoch of the written result.
- drop_count  out  16  saturating count of discarded stale results.

Behaviour:
- Reset values:
  - All holding buffers invalid; rr_ptr=0; cur_epoch=0.
  - wb_valid=0; wb_pd/wb_data/wb_epoch=0; drop_count=0.
  - req_ready = all 1 (all buffers empty).
- Holding buffer i (valid bit, pd, data, epoch):
  - req_ready[i] = !buf_v[i] || grant[i] (combinational; no dependence on req_valid).
  - Accept = req_valid[i] && req_ready[i]. The buffer loads at the clock edge.
  - Exception: if the accepted epoch != effective epoch, the buffer is not loaded and drop_count increments.
  - Effective epoch = flush_epoch if flush_valid, else cur_epoch.
- Eligibility: buf_v[i] && buf_epoch[i]==cur_epoch && !flush_valid.
- Arbitration:
  - One-hot grant to the first eligible buffer scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On grant g: rr_ptr <= (g+1) mod NUM_REQ; buf_v[g] cleared unless refilled the same cycle (a same-cycle accept overwrites the buffer, so back-to-back issue is possible).
  - No grant: rr_ptr holds.
- Output register:
  - On grant: wb_valid<=1 and wb_pd/data/epoch <= buffer contents.
  - Otherwise wb_valid<=0; payload holds its last value.
- Latency: accept at cycle N -> earliest wb_valid at N+2. Sustained throughput is 1 write/cycle aggregate.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1. No requester waits more than NUM_REQ-1 grants.
- Stale buffered entries (buf_v && buf_epoch != cur_epoch, no flush): cleared at the next edge and counted.
- Flush cycle:
  - cur_epoch <= flush_epoch.
  - No grant; wb_valid<=0 next cycle.
  - Every buffer with epoch != flush_epoch is invalidated and counted.
  - Buffers already tagged flush_epoch are retained.
  - Incoming accepts are filtered against flush_epoch.
- drop_count: adds the number of discards in the cycle (buffer discards + incoming discards, up to 2*NUM_REQ). Saturates at 16'hFFFF and never wraps.
- Does not deduplicate pd; the PRF performs its own epoch check on wb_epoch.
- Reset mid-operation: all state returns to reset values asynchronously. Pending results are lost.

Test Plan:
- Single request: req0 pd=5, data=0xDEAD_BEEF, epoch=0 at cycle 1 -> wb_valid=1 at cycle 3 with pd=5, data=0xDEAD_BEEF, epoch=0; req_ready[0] stays 1.
- All 4 requesters valid continuously for 8 cycles, epoch=0 -> grants 0,1,2,3,0,1,2,3; wb_valid=1 every cycle from the 3rd; each req_ready[i] high only in its grant cycle once buffers fill.
- Flush: buffers 1,2 hold epoch 0; flush_valid with flush_epoch=1 -> no wb the next cycle, both buffers cleared, drop_count=2, later epoch-1 requests written normally.
- Flush coincident with new requests: req0 epoch=0 and req1 epoch=1 during flush to 1 -> req0 dropped (drop_count+1), req1 written 2 cycles later.
- Backpressure: req2 buffer full while req0,req1 win -> req_ready[2]=0 until its grant; data is held unchanged and written exactly once.
- Saturation/reset: preload drop_count to 0xFFFE, drop 3 -> reads 0xFFFF; assert rst_n=0 mid-stream -> wb_valid=0, drop_count=0, req_ready all 1 immediately.

Source files
------------

// File: rtl/prf_wb_arbiter.sv
// Purpose : shares the PRF writeback port between NUM_REQ FU completion streams;
//           each requester has a 1-entry holding buffer, round-robin grant, stale-epoch discard.
// Latency : accept at cycle N -> earliest wb_valid at N+2; aggregate 1 write/cycle.
// Backpressure: req_ready[i] = buffer i empty or being granted (independent of req_valid).
// Ports   : clk/rst_n (async active-low); req_valid/req_ready/req_pd/req_data/req_epoch
//           are flattened per-requester vectors (requester i at slice i); flush_valid/flush_epoch
//           start a new epoch; wb_* is the registered PRF write port; drop_count is a
//           saturating count of discarded stale results.
module prf_wb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PHYS_REGS = 64,
    parameter int DW        = 32,
    parameter int PHYS_W    = $clog2(PHYS_REGS),
    parameter int EPOCH_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*PHYS_W-1:0]   req_pd,
    input  logic [NUM_REQ*DW-1:0]       req_data,
    input  logic [NUM_REQ*EPOCH_W-1:0]  req_epoch,
    input  logic                        flush_valid,
    input  logic [EPOCH_W-1:0]          flush_epoch,
    output logic                        wb_valid,
    output logic [PHYS_W-1:0]           wb_pd,
    output logic [DW-1:0]               wb_data,
    output logic [EPOCH_W-1:0]          wb_epoch,
    output logic [15:0]                 drop_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(2 * NUM_REQ + 1);

    logic [NUM_REQ-1:0]  buf_v;
    logic [PHYS_W-1:0]   buf_pd    [NUM_REQ];
    logic [DW-1:0]       buf_data  [NUM_REQ];
    logic [EPOCH_W-1:0]  buf_epoch [NUM_REQ];

    logic [PTR_W-1:0]    rr_ptr;
    logic [EPOCH_W-1:0]  cur_epoch;
    logic [EPOCH_W-1:0]  eff_epoch;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic                any_grant;
    logic [PTR_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  accept;
    logic [NUM_REQ-1:0]  load;
    logic [NUM_REQ-1:0]  in_drop;
    logic [NUM_REQ-1:0]  buf_drop;
    logic [CNT_W-1:0]    n_drops;
    logic [16:0]         drop_sum;

    // Incoming results are judged against the epoch that will be current after this edge.
    assign eff_epoch = flush_valid ? flush_epoch : cur_epoch;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = buf_v[i] && (buf_epoch[i] == cur_epoch) && !flush_valid;
        end
    end

    // Round-robin scan starting at rr_ptr; first eligible buffer wins.
    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_c;
        idx       = 0;
        idx_c     = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_c = PTR_W'(idx);
            if (!any_grant && eligible[idx_c]) begin
                any_grant    = 1'b1;
                grant_idx    = idx_c;
                grant[idx_c] = 1'b1;
            end
        end
    end

    assign req_ready = ~buf_v | grant;
    assign accept    = req_valid & req_ready;

    always_comb begin
        n_drops = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_drop[i]  = accept[i] && (req_epoch[i*EPOCH_W +: EPOCH_W] != eff_epoch);
            load[i]     = accept[i] && !in_drop[i];
            // A granted buffer is never stale, so grant and stale-discard cannot overlap.
            buf_drop[i] = buf_v[i] && !grant[i] && (buf_epoch[i] != eff_epoch);
            n_drops     = n_drops + CNT_W'(in_drop[i]) + CNT_W'(buf_drop[i]);
        end
    end

    assign drop_sum = {1'b0, drop_count} + 17'(n_drops);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v      <= '0;
            rr_ptr     <= '0;
            cur_epoch  <= '0;
            wb_valid   <= 1'b0;
            wb_pd      <= '0;
            wb_data    <= '0;
            wb_epoch   <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_pd[i]    <= '0;
                buf_data[i]  <= '0;
                buf_epoch[i] <= '0;
            end
        end else begin
            cur_epoch  <= eff_epoch;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            // Load takes priority over clear so a granted buffer can refill in the same cycle.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load[i]) begin
                    buf_v[i]     <= 1'b1;
                    buf_pd[i]    <= req_pd[i*PHYS_W +: PHYS_W];
                    buf_data[i]  <= req_data[i*DW +: DW];
                    buf_epoch[i] <= req_epoch[i*EPOCH_W +: EPOCH_W];
                end else if (grant[i] || buf_drop[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end

            wb_valid <= any_grant;
            if (any_grant) begin
                wb_pd    <= buf_pd[grant_idx];
                wb_data  <= buf_data[grant_idx];
                wb_epoch <= buf_epoch[grant_idx];
                rr_ptr   <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Purpose : self-checking bench for prf_wb_arbiter against a behavioural model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_prf_wb_arbiter;
    localparam int N  = 4;
    localparam int PW = 6;
    localparam int DW = 32;
    localparam int EW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*PW-1:0]   req_pd;
    logic [N*DW-1:0]   req_data;
    logic [N*EW-1:0]   req_epoch;
    logic              flush_valid;
    logic [EW-1:0]     flush_epoch;
    logic              wb_valid;
    logic [PW-1:0]     wb_pd;
    logic [DW-1:0]     wb_data;
    logic [EW-1:0]     wb_epoch;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    prf_wb_arbiter #(.NUM_REQ(N), .PHYS_REGS(64), .DW(DW), .EPOCH_W(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pd(req_pd), .req_data(req_data), .req_epoch(req_epoch),
        .flush_valid(flush_valid), .flush_epoch(flush_epoch),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data), .wb_epoch(wb_epoch),
        .drop_count(drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: buffers as plain arrays, pointer as an int.
    bit          m_v   [N];
    int          m_pd  [N];
    logic [31:0] m_dat [N];
    int          m_ep  [N];
    int          m_ptr, m_cur, m_drops;
    bit          m_wv;
    int          m_wpd, m_wep;
    logic [31:0] m_wdat;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_pd[i] = 0; m_dat[i] = '0; m_ep[i] = 0;
        end
        m_ptr = 0; m_cur = 0; m_drops = 0;
        m_wv = 0; m_wpd = 0; m_wep = 0; m_wdat = '0;
    endtask

    function automatic int m_grant();
        int j;
        if (flush_valid) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (m_v[j] && m_ep[j] == m_cur) return j;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int eff, nd;
        bit rdy [N];
        eff = flush_valid ? int'(flush_epoch) : m_cur;
        nd  = 0;
        for (int i = 0; i < N; i++) rdy[i] = !m_v[i] || (g == i);
        if (g >= 0) begin
            m_wv = 1; m_wpd = m_pd[g]; m_wdat = m_dat[g]; m_wep = m_ep[g];
            m_v[g] = 0;
            m_ptr = (g + 1) % N;
        end else begin
            m_wv = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_ep[i] != eff) begin
                m_v[i] = 0; nd++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && rdy[i]) begin
                if (int'(req_epoch[i*EW +: EW]) == eff) begin
                    m_v[i] = 1;
                    m_pd[i] = int'(req_pd[i*PW +: PW]);
                    m_dat[i] = req_data[i*DW +: DW];
                    m_ep[i] = eff;
                end else begin
                    nd++;
                end
            end
        end
        m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
        m_cur = eff;
    endtask

    // Called with inputs already driven (just after a rising edge).
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int g;
        #1;
        g = m_grant();
        for (int i = 0; i < N; i++) exp_rdy[i] = !m_v[i] || (g == i);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        model_update(g);
        #1;
        chk("wb_valid",   64'(wb_valid),   64'(m_wv));
        chk("wb_pd",      64'(wb_pd),      64'(m_wpd));
        chk("wb_data",    64'(wb_data),    64'(m_wdat));
        chk("wb_epoch",   64'(wb_epoch),   64'(m_wep));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_pd = '0; req_data = '0; req_epoch = '0;
        flush_valid = 1'b0; flush_epoch = '0;
    endtask

    task automatic set_req(input int i, input int pd, input logic [31:0] d, input int ep);
        req_valid[i] = 1'b1;
        req_pd[i*PW +: PW] = PW'(pd);
        req_data[i*DW +: DW] = d;
        req_epoch[i*EW +: EW] = EW'(ep);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_wb_valid",   64'(wb_valid),   64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_req_ready",  64'(req_ready),  64'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(2) != 0) begin
                set_req(i, int'($urandom_range(63)), 32'($urandom),
                        ($urandom_range(4) == 0) ? int'($urandom_range(3)) : m_cur);
            end
        end
        if ($urandom_range(11) == 0) begin
            flush_valid = 1'b1;
            flush_epoch = EW'($urandom_range(3));
        end
    endtask

    int exp_pd;

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        do_reset();

        // Single request: visible two edges after acceptance.
        set_req(0, 5, 32'hDEAD_BEEF, 0);
        cycle();
        idle_inputs();
        cycle();
        chk("single_valid", 64'(wb_valid), 64'd1);
        chk("single_pd",    64'(wb_pd),    64'd5);
        chk("single_data",  64'(wb_data),  64'hDEAD_BEEF);
        chk("single_ready", 64'(req_ready[0]), 64'd1);

        // All requesters continuously valid: grants rotate 0,1,2,3,...
        do_reset();
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            for (int i = 0; i < N; i++) set_req(i, i, 32'(100 * c + i), 0);
            cycle();
            if (c >= 1) begin
                exp_pd = (c - 1) % N;
                chk("rr_valid", 64'(wb_valid), 64'd1);
                chk("rr_order", 64'(wb_pd),    64'(exp_pd));
            end
        end

        // Flush drops epoch-0 buffers 1 and 2.
        do_reset();
        set_req(1, 11, 32'h1111, 0);
        set_req(2, 22, 32'h2222, 0);
        cycle();
        idle_inputs();
        flush_valid = 1'b1; flush_epoch = 2'd1;
        cycle();
        chk("flush_no_wb",  64'(wb_valid),   64'd0);
        chk("flush_drops",  64'(drop_count), 64'd2);
        idle_inputs();
        set_req(3, 33, 32'h3333, 1);
        cycle();
        idle_inputs();
        cycle();
        chk("post_flush_pd", 64'(wb_pd), 64'd33);

        // Flush coincident with new requests.
        idle_inputs();
        flush_valid = 1'b1; flush_epoch = 2'd2;
        set_req(0, 7, 32'h7777, 1);
        set_req(1, 8, 32'h8888, 2);
        cycle();
        chk("coinc_drops", 64'(drop_count), 64'd3);
        idle_inputs();
        cycle();
        chk("coinc_pd", 64'(wb_pd), 64'd8);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset mid-stream.
        rand_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_wb_valid", 64'(wb_valid),   64'd0);
        chk("mid_rst_drops",    64'(drop_count), 64'd0);
        chk("mid_rst_ready",    64'(req_ready),  64'hF);
        do_reset();

        // Saturation: every accept is stale.
        for (int c = 0; c < 16400; c++) begin
            idle_inputs();
            for (int i = 0; i < N; i++) set_req(i, i, 32'(c), 1);
            cycle();
        end
        chk("sat_drop_count", 64'(drop_count), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
